// File: rtl/ha_row_accum_seq.sv
`default_nettype none
// ha_row_accum_seq: accumulates four latched half-adder rows (shifted 2 bits per row) into a saturated 16-bit product.
// Build macro HA_SEQ_BIAS_EN adds parameter BIAS to the final sum. Rev 1.0
module ha_row_accum_seq #(
  parameter logic [15:0] BIAS = 16'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  row0_b,
  input  logic [6:0]  row1_b,
  input  logic [6:0]  row2_b,
  input  logic [6:0]  row3_b,
  input  logic [8:0]  row0_t,
  input  logic [8:0]  row1_t,
  input  logic [8:0]  row2_t,
  input  logic [8:0]  row3_t,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] prod,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [16:0] acc_q, acc_d;
  logic [15:0] prod_q, prod_d;
  logic        armed_q;
  logic [8:0]  t_q [4];
  logic [6:0]  b_q [4];

  logic        accept;
  logic [10:0] row_val;
  logic [16:0] term;
  logic [17:0] final_sum;

  assign accept  = in_valid && in_ready;
  assign row_val = {2'b00, t_q[cnt_q]} + {2'b00, b_q[cnt_q], 2'b00};
  assign term    = {6'd0, row_val} << {cnt_q, 1'b0};

  // Final sum is one bit wider than the accumulator so the bias cannot wrap before saturation.
`ifdef HA_SEQ_BIAS_EN
  assign final_sum = {1'b0, acc_q} + {1'b0, term} + {2'b00, BIAS};
`else
  logic unused_bias;
  assign unused_bias = ^BIAS;
  assign final_sum   = {1'b0, acc_q} + {1'b0, term};
`endif

  assign in_ready  = (state_q == IDLE) && armed_q;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign prod      = prod_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = 17'd0;
          cnt_d   = 2'd0;
          state_d = ACC;
        end
      end
      ACC: begin
        acc_d = acc_q + term;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          prod_d  = (final_sum > 18'h0FFFF) ? 16'hFFFF : final_sum[15:0];
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      acc_q   <= 17'd0;
      prod_q  <= 16'd0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      armed_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        t_q[i] <= 9'd0;
        b_q[i] <= 7'd0;
      end
    end else if (accept) begin
      t_q[0] <= row0_t;
      t_q[1] <= row1_t;
      t_q[2] <= row2_t;
      t_q[3] <= row3_t;
      b_q[0] <= row0_b;
      b_q[1] <= row1_b;
      b_q[2] <= row2_b;
      b_q[3] <= row3_b;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ha_row_accum_seq.sv
`default_nettype none
// tb_ha_row_accum_seq: table vectors, corner sequences and random row sets against an arithmetic model.
module tb_ha_row_accum_seq;

  localparam logic [15:0] BIAS_TB = 16'h0200;
`ifdef HA_SEQ_BIAS_EN
  localparam logic [15:0] BADD = BIAS_TB;
  localparam logic [15:0] E3   = 16'hFFFF;
`else
  localparam logic [15:0] BADD = 16'h0000;
  localparam logic [15:0] E3   = 16'hFEC0;
`endif

  typedef struct {
    logic [3:0][8:0] t;
    logic [3:0][6:0] b;
    logic [15:0]     exp;
  } vec_t;

  logic            clk;
  logic            rst_n;
  logic [3:0][8:0] t_in;
  logic [3:0][6:0] b_in;
  logic            in_valid;
  logic            in_ready;
  logic [15:0]     prod;
  logic            out_valid;
  logic            out_ready;
  logic            busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  ha_row_accum_seq #(.BIAS(BIAS_TB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .row0_b   (b_in[0]),
    .row1_b   (b_in[1]),
    .row2_b   (b_in[2]),
    .row3_b   (b_in[3]),
    .row0_t   (t_in[0]),
    .row1_t   (t_in[1]),
    .row2_t   (t_in[2]),
    .row3_t   (t_in[3]),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .prod     (prod),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Row i is worth t + 4*b, weighted by 4^i; optional bias, then clamp to 16 bits.
  function automatic logic [15:0] model(input logic [3:0][8:0] t, input logic [3:0][6:0] b);
    longint s = 0;
    for (int i = 0; i < 4; i++)
      s += (longint'(t[i]) + 4 * longint'(b[i])) * (longint'(1) << (2 * i));
`ifdef HA_SEQ_BIAS_EN
    s += longint'(BIAS_TB);
`endif
    return (s > 65535) ? 16'hFFFF : s[15:0];
  endfunction

  function automatic vec_t mk(input logic [8:0] t0, t1, t2, t3,
                              input logic [6:0] b0, b1, b2, b3,
                              input logic [15:0] e);
    vec_t v;
    v.t   = {t3, t2, t1, t0};
    v.b   = {b3, b2, b1, b0};
    v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Starts and ends at a falling edge; the result is sampled in the first DONE cycle.
  // lat counts cycles with the accepting cycle as cycle 0.
  task automatic do_op(input logic [3:0][8:0] t, input logic [3:0][6:0] b,
                       output logic [15:0] got, output int lat);
    int w;
    t_in     = t;
    b_in     = b;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) check("accept_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    t_in     = {$urandom, $urandom};
    b_in     = $urandom;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    got = prod;
  endtask

  vec_t            tbl [8];
  logic [15:0]     got;
  int              lat;
  int              bad;
  int              last_cyc;
  logic [3:0][8:0] vt_t [5];
  logic [3:0][6:0] vt_b [5];
  logic [3:0][8:0] rt;
  logic [3:0][6:0] rb;

  initial begin
    tbl[0] = mk(9'd1, 9'd0, 9'd0, 9'd0, 7'd0, 7'd0, 7'd0, 7'd0, 16'h0001 + BADD);
    tbl[1] = mk(9'd0, 9'd0, 9'd0, 9'd0, 7'd0, 7'd0, 7'd0, 7'h40, 16'h4000 + BADD);
    tbl[2] = mk(9'd0, 9'h1FF, 9'd0, 9'd0, 7'd0, 7'd0, 7'd0, 7'd0, 16'h07FC + BADD);
    tbl[3] = mk(9'd0, 9'd0, 9'd0, 9'h1FF, 7'd0, 7'd0, 7'd0, 7'h7F, E3);
    tbl[4] = mk(9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 16'hFFFF);
    tbl[5] = mk(9'd0, 9'd0, 9'd0, 9'd0, 7'd1, 7'd0, 7'd0, 7'd0, 16'h0004 + BADD);
    tbl[6] = mk(9'd0, 9'd0, 9'd3, 9'd0, 7'd0, 7'd0, 7'd0, 7'd0, 16'h0030 + BADD);
    tbl[7] = mk(9'h1FF, 9'd0, 9'd0, 9'd0, 7'd0, 7'h7F, 7'd0, 7'd0, 16'h09EF + BADD);

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    t_in      = '0;
    b_in      = '0;
    #1;
    check("reset_prod", {16'd0, prod}, 32'd0);
    check("reset_flags", {29'd0, out_valid, busy, in_ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_before_first_edge", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("ready_after_first_edge", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 8; i++) begin
      do_op(tbl[i].t, tbl[i].b, got, lat);
      check($sformatf("vec%0d_prod", i), {16'd0, got}, {16'd0, tbl[i].exp});
      check($sformatf("vec%0d_latency", i), lat, 5);
      check($sformatf("vec%0d_no_ready_in_done", i), {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      check($sformatf("vec%0d_idle_hold", i), {14'd0, busy, out_valid, prod}, {16'd0, tbl[i].exp});
    end

    // Consumer stalls for 10 cycles while in_valid and rows churn.
    out_ready = 1'b0;
    do_op(tbl[2].t, tbl[2].b, got, lat);
    check("stall_prod", {16'd0, got}, {16'd0, tbl[2].exp});
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      t_in     = {$urandom, $urandom};
      b_in     = $urandom;
      @(negedge clk);
      if (out_valid !== 1'b1 || prod !== tbl[2].exp || in_ready !== 1'b0) bad++;
    end
    check("stall_unstable_cycles", bad, 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("stall_release", {13'd0, busy, out_valid, in_ready, prod}, {16'd1, tbl[2].exp});

    // Reset while cnt==2.
    t_in     = tbl[7].t;
    b_in     = tbl[7].b;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_prod", {16'd0, prod}, 32'd0);
    check("midrst_flags", {29'd0, out_valid, busy, in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
    end
    check("midrst_no_valid", bad, 0);
    do_op(tbl[6].t, tbl[6].b, got, lat);
    check("midrst_next_prod", {16'd0, got}, {16'd0, tbl[6].exp});
    check("midrst_next_latency", lat, 5);
    @(negedge clk);

    // in_valid held high: back-to-back operations.
    for (int k = 0; k < 5; k++) begin
      vt_t[k] = {$urandom, $urandom};
      vt_b[k] = $urandom;
    end
    t_in     = vt_t[0];
    b_in     = vt_b[0];
    in_valid = 1'b1;
    last_cyc = 0;
    for (int op = 0; op < 4; op++) begin
      int w;
      w = 0;
      while (!in_ready && w < 20) begin
        @(negedge clk);
        w++;
      end
      check($sformatf("b2b%0d_ready", op), {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      t_in = vt_t[op + 1];
      b_in = vt_b[op + 1];
      w = 0;
      while (!out_valid && w < 20) begin
        @(negedge clk);
        w++;
      end
      if (op == 3) in_valid = 1'b0;
      check($sformatf("b2b%0d_prod", op), {16'd0, prod}, {16'd0, model(vt_t[op], vt_b[op])});
      if (op > 0) check($sformatf("b2b%0d_spacing", op), cyc - last_cyc, 6);
      last_cyc = cyc;
    end
    @(negedge clk);

    // Random row sets against the model.
    for (int n = 0; n < 20; n++) begin
      rt = {$urandom, $urandom};
      rb = $urandom;
      if (n % 4 == 0) rt = '1;
      do_op(rt, rb, got, lat);
      check($sformatf("rand%0d_prod", n), {16'd0, got}, {16'd0, model(rt, rb)});
      check($sformatf("rand%0d_latency", n), lat, 5);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ha_row_accum_seq.md
HA_ROW_ACCUM_SEQ -- requirements
Module: ha_row_accum_seq

Interface
REQ-001 SHALL have parameter BIAS, default 16'd0, constant added to the final product when HA_SEQ_BIAS_EN is defined.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have ports row0_b/row1_b/row2_b/row3_b  input  7 each  carry vector of half-adder row i.
REQ-005 SHALL have ports row0_t/row1_t/row2_t/row3_t  input  9 each  sum vector of half-adder row i.
REQ-006 SHALL have port in_valid  input  1  the row vectors are valid.
REQ-007 SHALL have port in_ready  output  1  the block can accept a row set.
REQ-008 SHALL have port prod  output  16  accumulated product.
REQ-009 SHALL have port out_valid  output  1  prod is valid.
REQ-010 SHALL have port out_ready  input  1  the consumer accepts prod.
REQ-011 SHALL have port busy  output  1  the state is not IDLE.

Function
REQ-012 SHALL compute row value Ri = rowi_t + (rowi_b << 2), an 11-bit unsigned value (t bit k weight 2^k; b bit k weight 2^(k+2)).
REQ-013 SHALL compute the sum S = R0 + (R1<<2) + (R2<<4) + (R3<<6) in a 17-bit accumulator.
REQ-014 SHALL implement states IDLE, ACC, DONE, with a 2-bit row counter cnt.
REQ-015 SHALL drive in_ready=1 only in IDLE; on in_valid&&in_ready it latches all eight row vectors, clears the accumulator, sets cnt=0 and enters ACC.
REQ-016 SHALL, in ACC, add (R[cnt] << 2*cnt) to the accumulator each cycle and increment cnt; on the cycle cnt==3 it enters DONE.
REQ-017 SHALL have fixed latency: out_valid rises exactly 5 cycles after the accepting edge (1 latch + 4 accumulate).
REQ-018 SHALL, in DONE, drive out_valid=1 and hold prod stable until out_ready=1, then return to IDLE on that edge.
REQ-019 SHALL saturate prod: if the final 17-bit value exceeds 16'hFFFF, prod=16'hFFFF; otherwise prod = the low 16 bits.
REQ-020 SHALL ignore in_valid outside IDLE; the latched rows are unaffected by input changes during ACC/DONE.
REQ-021 SHALL NOT assert in_ready in the DONE cycle that has out_ready=1; a new row set is accepted no earlier than the following cycle (throughput 1 result per 6 cycles minimum).
REQ-022 SHALL hold prod at its last value when out_valid=0 outside DONE, and at 0 after reset.

Reset
REQ-023 SHALL, with rst_n=0, immediately force state=IDLE, cnt=0, accumulator=0, prod=0, out_valid=0, busy=0, in_ready=0 (in_ready goes to 1 at the first clock edge after release).
REQ-024 SHALL discard an in-flight operation on reset mid-ACC or mid-DONE; no out_valid is produced for it.

Configuration
REQ-025 SHALL, with HA_SEQ_BIAS_EN defined, compute the final value = S + BIAS (17-bit) before REQ-019 saturation, adding BIAS once in the DONE transition with no extra cycle of latency.
REQ-026 SHALL, without HA_SEQ_BIAS_EN, ignore BIAS entirely and contain no bias adder.

Verification
REQ-027 SHALL cover: row0_t=9'd1, all others 0 -> prod=16'h0001 with out_valid exactly 5 cycles after the accept.
REQ-028 SHALL cover: row3_b=7'h40, all others 0 -> prod=16'h4000; row1_t=9'h1FF alone -> prod=16'h07FC.
REQ-029 SHALL cover: row3_t=9'h1FF, row3_b=7'h7F, others 0, BIAS=16'h0200 -> prod=16'hFEC0 without HA_SEQ_BIAS_EN and 16'hFFFF with it; all rows all-ones -> prod=16'hFFFF (saturation).
REQ-030 SHALL cover: out_ready held low for 10 cycles in DONE -> prod/out_valid stable and in_ready=0 throughout; in_valid toggling during that time has no effect.
REQ-031 SHALL cover: rst_n pulsed low at cnt==2 -> outputs zero asynchronously, no out_valid, the next accepted set computes correctly.
REQ-032 SHALL cover: in_valid held high continuously with out_ready=1 -> results on consecutive operations spaced 6 cycles apart, each matching its row set.
